// File: rtl/trasmettitore_seriale_pkg.sv
// Shared definitions for the serial transmitter: FSM encoding and default sizing.
package trasmettitore_seriale_pkg;

  localparam int unsigned DefDataW     = 8;
  localparam int unsigned DefBitCycles = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StWait  = 3'd4
  } stato_e;

endpackage

// File: rtl/trasmettitore_seriale_contatore_modulo.sv
// Modulo-N counter with enable and synchronous clear; tc_o marks the wrapping cycle.
module contatore_modulo #(
  parameter int unsigned Modulo = 4,
  parameter int unsigned Width  = 2
) (
  input  logic clk_i,
  input  logic en_i,
  input  logic clear_i,
  output logic tc_o
);

  logic [Width-1:0] count_q, count_d;

  assign tc_o = en_i && (count_q == Width'(Modulo - 1));

  // Next count: clear wins, otherwise count while enabled and wrap on terminal count.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

endmodule

// File: rtl/trasmettitore_seriale.sv
// Serial transmitter: start bit 0, DATA_W data bits LSB first, stop bit 1,
// each bit held for BIT_CYCLES clocks. Handshake via active-low dav_ / rfd.
module trasmettitore_seriale
  import trasmettitore_seriale_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = DefBitCycles,
  parameter int unsigned DATA_W     = DefDataW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dav_,
  input  logic [DATA_W-1:0] byte_in,
  output logic              rfd,
  output logic              out,
  output logic              busy
);

  localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  stato_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              out_q, out_d;
  logic              rfd_q, rfd_d;
  logic              busy_q, busy_d;
  logic              capture, cnt_en, tick, last_bit;

  assign capture  = (state_q == StIdle) && !dav_;
  assign cnt_en   = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  assign last_bit = (idx_q == IdxW'(DATA_W - 1));

  // Bit-period timer; restarted at capture so the start bit lasts a full period.
  contatore_modulo #(
    .Modulo (BIT_CYCLES),
    .Width  (CntW)
  ) u_bit_timer (
    .clk_i   (clock),
    .en_i    (cnt_en),
    .clear_i (reset | capture),
    .tc_o    (tick)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; each bit-period tick advances the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!dav_) state_d = StStart;
      StStart: if (tick) state_d = StData;
      StData:  if (tick && last_bit) state_d = StStop;
      StStop:  if (tick) state_d = dav_ ? StIdle : StWait;
      StWait:  if (dav_) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values; outputs are registered below.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    out_d   = out_q;
    rfd_d   = rfd_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (!dav_) begin
          shift_d = byte_in;
          idx_d   = '0;
          out_d   = 1'b0;
          rfd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          out_d   = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
        end
      end
      StData: begin
        if (tick) begin
          if (last_bit) begin
            out_d = 1'b1;
            idx_d = '0;
          end else begin
            out_d   = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          busy_d = 1'b0;
          out_d  = 1'b1;
          rfd_d  = dav_;
        end
      end
      StWait: begin
        if (dav_) rfd_d = 1'b1;
      end
      default: begin
        out_d  = 1'b1;
        rfd_d  = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      out_q   <= 1'b1;
      rfd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      rfd_q   <= rfd_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign rfd  = rfd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_trasmettitore_seriale.sv
// Bench for trasmettitore_seriale: one instance at BIT_CYCLES=4, one at BIT_CYCLES=1.
module tb_trasmettitore_seriale;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dav_a = 1'b1, dav_b = 1'b1;
  logic [7:0] byte_a = 8'h00, byte_b = 8'h00;
  logic       rfd_a, out_a, busy_a;
  logic       rfd_b, out_b, busy_b;
  int         sel = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clock = ~clock;

  trasmettitore_seriale #(.BIT_CYCLES(4), .DATA_W(8)) dut4 (
    .clock   (clock),
    .reset   (reset),
    .dav_    (dav_a),
    .byte_in (byte_a),
    .rfd     (rfd_a),
    .out     (out_a),
    .busy    (busy_a)
  );

  trasmettitore_seriale #(.BIT_CYCLES(1), .DATA_W(8)) dut1 (
    .clock   (clock),
    .reset   (reset),
    .dav_    (dav_b),
    .byte_in (byte_b),
    .rfd     (rfd_b),
    .out     (out_b),
    .busy    (busy_b)
  );

  function automatic int bc_sel();
    return (sel == 0) ? 4 : 1;
  endfunction

  // Observed {out, busy, rfd} of the selected instance.
  function automatic logic [2:0] obs();
    return (sel == 0) ? {out_a, busy_a, rfd_a} : {out_b, busy_b, rfd_b};
  endfunction

  task automatic set_in(input logic d, input logic [7:0] b);
    if (sel == 0) begin dav_a = d; byte_a = b; end
    else begin dav_b = d; byte_b = b; end
  endtask

  task automatic set_dav(input logic d);
    if (sel == 0) dav_a = d; else dav_b = d;
  endtask

  task automatic set_byte(input logic [7:0] b);
    if (sel == 0) byte_a = b; else byte_b = b;
  endtask

  // Reference: expected {out, busy, rfd} k edges after capture edge E0 (k=0 is E0),
  // for a frame of byte d, dav_ held low for 'hold' edges starting at E0.
  function automatic logic [2:0] model(input int k, input logic [7:0] d, input int hold,
                                       input int bc);
    logic [9:0] fr;
    int n;
    fr = {1'b1, d, 1'b0};
    n  = 10 * bc;
    if (k < n) return {fr[k / bc], 1'b1, 1'b0};
    return {1'b1, 1'b0, (k >= hold)};
  endfunction

  // Reset held with dav_ low: no frame; then capture on the first edge after release.
  task automatic test_reset();
    logic [7:0] d;
    sel = 0;
    d = 8'($urandom);
    reset = 1'b1;
    set_in(1'b0, d);
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      n_tests++;
      if ({out_a, busy_a, rfd_a} !== 3'b101) begin
        n_fail++;
        $display("FAIL reset_idle_bc4 k=%0d got=%b want=101", k, {out_a, busy_a, rfd_a});
      end
      n_tests++;
      if ({out_b, busy_b, rfd_b} !== 3'b101) begin
        n_fail++;
        $display("FAIL reset_idle_bc1 k=%0d got=%b want=101", k, {out_b, busy_b, rfd_b});
      end
    end
    reset = 1'b0;
    for (int k = 0; k <= 41; k++) begin
      @(posedge clock); #1;
      n_tests++;
      if (obs() !== model(k, d, 1, 4)) begin
        n_fail++;
        $display("FAIL reset_release_capture k=%0d got=%b want=%b", k, obs(), model(k, d, 1, 4));
      end
      set_dav(1'b1);
    end
  endtask

  // Fixed A5 frame against a literal bit table.
  task automatic test_a5();
    logic [9:0] seq;
    logic [2:0] want;
    seq = 10'b1101001010;  // seq[i] = i-th bit on the line
    sel = 0;
    set_in(1'b0, 8'hA5);
    for (int k = 0; k <= 41; k++) begin
      @(posedge clock); #1;
      set_dav(1'b1);
      want = (k < 40) ? {seq[k / 4], 2'b10} : 3'b101;
      n_tests++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL a5_frame k=%0d got=%b want=%b", k, obs(), want);
      end
    end
  endtask

  // dav_ held low 100 cycles: one frame, then wait, rfd rises after dav_ returns high.
  task automatic test_hold();
    sel = 0;
    set_in(1'b0, 8'h3C);
    for (int k = 0; k <= 104; k++) begin
      @(posedge clock); #1;
      n_tests++;
      if (obs() !== model(k, 8'h3C, 100, 4)) begin
        n_fail++;
        $display("FAIL hold_low k=%0d got=%b want=%b", k, obs(), model(k, 8'h3C, 100, 4));
      end
      if (k + 1 >= 100) set_dav(1'b1);
    end
  endtask

  // byte_in changes after capture must not affect the frame.
  task automatic test_late_byte();
    sel = 0;
    set_in(1'b0, 8'h11);
    for (int k = 0; k <= 41; k++) begin
      @(posedge clock); #1;
      n_tests++;
      if (obs() !== model(k, 8'h11, 1, 4)) begin
        n_fail++;
        $display("FAIL late_byte k=%0d got=%b want=%b", k, obs(), model(k, 8'h11, 1, 4));
      end
      set_dav(1'b1);
      if (k == 5) set_byte(8'hEE);
    end
  endtask

  // Reset 15 cycles into a frame aborts it; next byte goes out intact.
  task automatic test_mid_reset();
    sel = 0;
    set_in(1'b0, 8'hC3);
    for (int k = 0; k < 15; k++) begin
      @(posedge clock); #1;
      n_tests++;
      if (obs() !== model(k, 8'hC3, 1, 4)) begin
        n_fail++;
        $display("FAIL mid_reset_pre k=%0d got=%b want=%b", k, obs(), model(k, 8'hC3, 1, 4));
      end
      set_dav(1'b1);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    n_tests++;
    if (obs() !== 3'b101) begin
      n_fail++;
      $display("FAIL mid_reset_abort got=%b want=101", obs());
    end
    reset = 1'b0;
    set_in(1'b0, 8'h0F);
    for (int k = 0; k <= 41; k++) begin
      @(posedge clock); #1;
      n_tests++;
      if (obs() !== model(k, 8'h0F, 1, 4)) begin
        n_fail++;
        $display("FAIL mid_reset_next k=%0d got=%b want=%b", k, obs(), model(k, 8'h0F, 1, 4));
      end
      set_dav(1'b1);
    end
  endtask

  // BIT_CYCLES=1: 00 then FF, second capture at E1+1.
  task automatic test_back_to_back();
    sel = 1;
    set_in(1'b0, 8'h00);
    for (int k = 0; k <= 10; k++) begin
      @(posedge clock); #1;
      n_tests++;
      if (obs() !== model(k, 8'h00, 1, 1)) begin
        n_fail++;
        $display("FAIL b2b_first k=%0d got=%b want=%b", k, obs(), model(k, 8'h00, 1, 1));
      end
      set_dav(1'b1);
      if (k == 10) set_in(1'b0, 8'hFF);
    end
    for (int k = 0; k <= 12; k++) begin
      @(posedge clock); #1;
      n_tests++;
      if (obs() !== model(k, 8'hFF, 1, 1)) begin
        n_fail++;
        $display("FAIL b2b_second k=%0d got=%b want=%b", k, obs(), model(k, 8'hFF, 1, 1));
      end
      set_dav(1'b1);
    end
  endtask

  // Random bytes, dav_ pulse lengths and byte_in disturbances on both instances.
  task automatic test_random();
    logic [7:0] d;
    int bc, n, hold, late_at, last;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int f = 0; f < 6; f++) begin
        d       = 8'($urandom);
        bc      = bc_sel();
        n       = 10 * bc;
        hold    = int'($urandom_range(1, n + 5));
        late_at = int'($urandom_range(0, n));
        last    = ((hold > n) ? hold : n) + 2;
        set_in(1'b0, d);
        for (int k = 0; k <= last; k++) begin
          @(posedge clock); #1;
          n_tests++;
          if (obs() !== model(k, d, hold, bc)) begin
            n_fail++;
            $display("FAIL random sel=%0d f=%0d k=%0d got=%b want=%b", s, f, k, obs(),
                     model(k, d, hold, bc));
          end
          if (k + 1 >= hold) set_dav(1'b1);
          if (k == late_at) set_byte(8'($urandom));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_hold();
    test_late_byte();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/trasmettitore_seriale.md
TRASMETTITORE_SERIALE -- requirements
Module: trasmettitore_seriale

Interface
REQ-001 Parameter: BIT_CYCLES, default 4, clock cycles per serial bit; legal range 1..256.
REQ-002 Parameter: DATA_W, default 8, bits per frame payload; legal range 1..16.
REQ-003 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: dav_  input  1  data-valid from producer, active-low.
REQ-006 Port: byte_in  input  DATA_W  payload, sampled only at the capture edge.
REQ-007 Port: rfd  output  1  ready-for-data to producer, active-high, registered.
REQ-008 Port: out  output  1  serial line, idle high, registered.
REQ-009 Port: busy  output  1  high while a frame is on the line, registered.

Function
REQ-010 Frame format SHALL be: start bit 0, DATA_W data bits LSB first, stop bit 1; each bit held on out for exactly BIT_CYCLES cycles.
REQ-011 States SHALL be IDLE, START, DATA, STOP, WAIT.
REQ-012 Capture edge E0: state IDLE and dav_=0 sampled -> byte_in latched into shift register, out<=0, rfd<=0, busy<=1, state START.
REQ-013 Data bit i SHALL be driven from edge E0+(i+1)*BIT_CYCLES; stop bit from E0+(DATA_W+1)*BIT_CYCLES.
REQ-014 End edge E1 = E0+(DATA_W+2)*BIT_CYCLES: busy<=0, out stays 1; dav_=1 sampled -> rfd<=1, IDLE; dav_=0 -> WAIT.
REQ-015 WAIT: dav_=1 sampled -> rfd<=1, IDLE; out=1, busy=0 throughout.
REQ-016 dav_ and byte_in changes outside the capture edge SHALL be ignored; exactly one frame per dav_ low pulse.
REQ-017 Earliest next capture SHALL be edge E1+1 (rfd=1 visible after E1, dav_=0 sampled at E1+1).
REQ-018 Bit-period counter width SHALL be ceil(log2(BIT_CYCLES)) with minimum 1; it wraps to 0 on terminal count BIT_CYCLES-1, and each wrap advances the bit.
REQ-019 Bit index counter SHALL count 0..DATA_W-1 in DATA; no wrap beyond DATA_W-1.
REQ-020 BIT_CYCLES=1: one bit per cycle, no idle cycles inserted within the frame.

Reset
REQ-021 reset=1 at an edge SHALL force state IDLE, out=1, rfd=1, busy=0, counters 0, shift register 0, overriding all other inputs.
REQ-022 Reset mid-frame SHALL abort the frame; out=1 from the edge where reset is sampled; no partial resume.
REQ-023 dav_=0 at the first edge after reset deassertion SHALL start a capture (rfd is already 1).

Structure
REQ-024 A shared package SHALL hold the state encoding (3-bit, five named constants) and the default DATA_W and BIT_CYCLES values.
REQ-025 One sub-module, contatore_modulo (modulo-N counter with enable, synchronous clear, terminal-count output), SHALL implement the bit-period timing.
REQ-026 out, rfd and busy SHALL be driven directly from flip-flops; no combinational path from inputs to outputs.

Verification
REQ-027 BIT_CYCLES=4, byte_in=8'hA5, dav_ pulsed low 1 cycle -> out = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; rfd low 40 cycles; busy high 40 cycles.
REQ-028 dav_ held low for 100 cycles, byte_in=8'h3C -> exactly one frame; state WAIT after 40 cycles; rfd rises one cycle after dav_ returns high.
REQ-029 byte_in changed 8'h11->8'hEE 5 cycles after capture -> the frame carries 8'h11.
REQ-030 reset asserted 15 cycles after capture -> out=1, rfd=1, busy=0 after that edge; new byte 8'h0F then sent correctly.
REQ-031 BIT_CYCLES=1, back-to-back bytes 8'h00 then 8'hFF with dav_ high at E1 -> second start bit begins at E1+1; frames 10 cycles each.
REQ-032 reset held high with dav_=0 -> no frame; out=1 and rfd=1 throughout.
